axi4_lite_io_slave: RTL and testbench

- AXI4-Lite slave peripheral that consumes the bus and external-signal bundle driven by the verification interface.
- Owns four memory-mapped registers: LED output, 7-segment value, IRQ enable and IRQ status.
- Drives the LED bank and a 4-digit multiplexed 7-segment display.
- Generates a level interrupt from the rising edge of EXT_IRQ_IN.

---
 rtl/axi4_lite_io_slave_if.sv | 37 +++
 rtl/axi4_lite_io_slave.sv | 151 +++++++++++++++
 tb/tb_axi4_lite_io_slave.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_io_slave_if.sv
// axi4_lite_io_slave_if: AXI4-Lite bus bundle between a master and the IO slave
interface axi4_lite_io_slave_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]              S_AXI_AWPROT;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]              S_AXI_ARPROT;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;
  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
           S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
           S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/axi4_lite_io_slave.sv
// axi4_lite_io_slave: AXI4-Lite slave with LED, 7-segment scan and edge-triggered IRQ registers
module axi4_lite_io_slave #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LEDS   = 8,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  axi4_lite_io_slave_if.slave  s_axi,
  input  logic                 EXT_IRQ_IN,
  output logic [NUM_LEDS-1:0]  LED,
  output logic [6:0]           SEG_CATHODE,
  output logic [3:0]           SEG_ANODE,
  output logic                 IRQ_OUT
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic awready_q, wready_q, arready_q, bvalid_q, rvalid_q, aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q, wmask, rd_val;
  logic [SW-1:0] wstrb_q;
  logic [1:0] bresp_q, rresp_q;
  logic [NUM_LEDS-1:0] led_q, led_out_q, led_m;
  logic [15:0] seg_q, seg_m;
  logic en_q, pend_q, irq_q;
  logic [2:0] sync_q;
  logic [CW-1:0] cnt_q;
  logic [1:0] idx_q;
  logic [3:0] anode_q;
  logic [6:0] cath_q;
  logic aw_fire, w_fire, ar_fire, do_wr, aw_held_d, w_held_d, bvalid_d, rvalid_d;
  logic wr_map, ar_map, wr_led, wr_seg, wr_en, wr_stat, clr, rise, wrap;
  logic [1:0] wr_idx, ar_idx;
  logic [3:0] digit;
  logic unused;
  assign aw_fire   = s_axi.S_AXI_AWVALID & awready_q;
  assign w_fire    = s_axi.S_AXI_WVALID & wready_q;
  assign ar_fire   = s_axi.S_AXI_ARVALID & arready_q;
  assign do_wr     = aw_held_q & w_held_q & ~bvalid_q;
  assign aw_held_d = aw_fire | (aw_held_q & ~do_wr);
  assign w_held_d  = w_fire | (w_held_q & ~do_wr);
  assign bvalid_d  = do_wr | (bvalid_q & ~s_axi.S_AXI_BREADY);
  assign rvalid_d  = ar_fire | (rvalid_q & ~s_axi.S_AXI_RREADY);
  assign wr_map  = awaddr_q[ADDR_WIDTH-1:4] == '0;
  assign ar_map  = s_axi.S_AXI_ARADDR[ADDR_WIDTH-1:4] == '0;
  assign wr_idx  = awaddr_q[3:2];
  assign ar_idx  = s_axi.S_AXI_ARADDR[3:2];
  assign wr_led  = do_wr & wr_map & (wr_idx == 2'd0);
  assign wr_seg  = do_wr & wr_map & (wr_idx == 2'd1);
  assign wr_en   = do_wr & wr_map & (wr_idx == 2'd2) & wstrb_q[0];
  assign wr_stat = do_wr & wr_map & (wr_idx == 2'd3);
  for (genvar i = 0; i < SW; i++) begin : g_mask
    assign wmask[8*i +: 8] = {8{wstrb_q[i]}};
  end
  assign led_m = (led_q & ~wmask[NUM_LEDS-1:0]) | (wdata_q[NUM_LEDS-1:0] & wmask[NUM_LEDS-1:0]);
  assign seg_m = (seg_q & ~wmask[15:0]) | (wdata_q[15:0] & wmask[15:0]);
  assign clr   = wr_stat & wstrb_q[0] & wdata_q[0];
  assign rise  = sync_q[1] & ~sync_q[2];
  assign rd_val = !ar_map ? '0 :
                  ar_idx == 2'd0 ? DATA_WIDTH'(led_q) :
                  ar_idx == 2'd1 ? DATA_WIDTH'(seg_q) :
                  ar_idx == 2'd2 ? DATA_WIDTH'(en_q) : DATA_WIDTH'(pend_q);
  assign wrap  = cnt_q == CW'(SCAN_DIV - 1);
  assign digit = seg_q[{idx_q, 2'b00} +: 4];
  assign unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, awaddr_q[1:0],
                    s_axi.S_AXI_ARADDR[1:0], wdata_q[DATA_WIDTH-1:16], wmask[DATA_WIDTH-1:16]};
  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign LED         = led_out_q;
  assign SEG_ANODE   = anode_q;
  assign SEG_CATHODE = cath_q;
  assign IRQ_OUT     = irq_q;
  // Bus handshakes: independent AW/W capture, write response and read data registers
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= OKAY;
      rresp_q   <= OKAY;
      rdata_q   <= '0;
    end else begin
      awready_q <= ~aw_held_d & ~bvalid_d;
      wready_q  <= ~w_held_d & ~bvalid_d;
      arready_q <= ~rvalid_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      if (aw_fire) awaddr_q <= s_axi.S_AXI_AWADDR;
      if (w_fire) begin
        wdata_q <= s_axi.S_AXI_WDATA;
        wstrb_q <= s_axi.S_AXI_WSTRB;
      end
      if (do_wr) bresp_q <= wr_map ? OKAY : SLVERR;
      if (ar_fire) begin
        rdata_q <= rd_val;
        rresp_q <= ar_map ? OKAY : SLVERR;
      end
    end
  // Register file, IRQ synchronizer/pending (set beats W1C) and registered LED/IRQ outputs
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      led_q     <= '0;
      led_out_q <= '0;
      seg_q     <= '0;
      en_q      <= 1'b0;
      pend_q    <= 1'b0;
      irq_q     <= 1'b0;
      sync_q    <= '0;
    end else begin
      led_q     <= wr_led ? led_m : led_q;
      led_out_q <= led_q;
      seg_q     <= wr_seg ? seg_m : seg_q;
      en_q      <= wr_en ? wdata_q[0] : en_q;
      pend_q    <= rise | (pend_q & ~clr);
      irq_q     <= pend_q & en_q;
      sync_q    <= {sync_q[1:0], EXT_IRQ_IN};
    end
  // Display scan: slot counter, digit index and registered anode/cathode drive
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      anode_q <= 4'b1111;
      cath_q  <= 7'h7F;
    end else begin
      cnt_q   <= wrap ? '0 : cnt_q + 1'b1;
      idx_q   <= idx_q + 2'(wrap);
      anode_q <= ~(4'b0001 << idx_q);
      cath_q  <= HEX[digit];
    end
endmodule

// File: tb/tb_axi4_lite_io_slave.sv
// tb_axi4_lite_io_slave: vector table plus handshake, IRQ, scan and reset sequences with a response scoreboard
module tb_axi4_lite_io_slave;
  logic clk = 1'b0;
  logic rst;
  logic ext;
  logic [7:0] led;
  logic [6:0] cath;
  logic [3:0] anode;
  logic irq;
  int n_vec = 0;
  int n_err = 0;
  logic [1:0] bq[$];
  logic [33:0] rq[$];
  always #5 clk = ~clk;
  axi4_lite_io_slave_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus();
  axi4_lite_io_slave #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_LEDS(8), .SCAN_DIV(4)) dut (
    .ACLK(clk), .ARESET(rst), .s_axi(bus), .EXT_IRQ_IN(ext),
    .LED(led), .SEG_CATHODE(cath), .SEG_ANODE(anode), .IRQ_OUT(irq)
  );
  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int w_lead, input int b_hold, input logic [1:0] exp, output int lat);
    bit aw_p = 1, w_p = 1, done = 0;
    int held = 0;
    logic [1:0] r0 = 2'b00;
    bq.push_back(exp);
    lat = -1;
    for (int c = 0; c < 64 && !done; c++) begin
      bus.S_AXI_AWADDR  = a;
      bus.S_AXI_WDATA   = d;
      bus.S_AXI_WSTRB   = s;
      bus.S_AXI_AWVALID = aw_p && c >= w_lead;
      bus.S_AXI_WVALID  = w_p;
      if (bus.S_AXI_BVALID && lat < 0) lat = c;
      bus.S_AXI_BREADY = bus.S_AXI_BVALID && held >= b_hold;
      if (bus.S_AXI_BVALID && !bus.S_AXI_BREADY) begin
        if (held > 0) chk("bresp_stable", bus.S_AXI_BRESP, r0);
        r0 = bus.S_AXI_BRESP;
        held++;
      end
      if (bus.S_AXI_BVALID && bus.S_AXI_BREADY) begin
        done = 1;
        chk("bresp", bus.S_AXI_BRESP, bq.pop_front());
      end
      if (bus.S_AXI_AWVALID && bus.S_AXI_AWREADY) aw_p = 0;
      if (bus.S_AXI_WVALID && bus.S_AXI_WREADY) w_p = 0;
      @(posedge clk);
      @(negedge clk);
    end
    bus.S_AXI_AWVALID = 0;
    bus.S_AXI_WVALID  = 0;
    bus.S_AXI_BREADY  = 0;
    chk("b_handshake", done, 1);
  endtask
  task automatic axi_read(input logic [4:0] a, input logic [1:0] er, input logic [31:0] ed, input int r_hold);
    bit ar_p = 1, done = 0;
    int held = 0;
    logic [33:0] e;
    rq.push_back({er, ed});
    for (int c = 0; c < 64 && !done; c++) begin
      bus.S_AXI_ARADDR  = a;
      bus.S_AXI_ARVALID = ar_p;
      bus.S_AXI_RREADY  = bus.S_AXI_RVALID && held >= r_hold;
      if (bus.S_AXI_RVALID && !bus.S_AXI_RREADY) held++;
      if (bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
        done = 1;
        e = rq.pop_front();
        chk("rresp", bus.S_AXI_RRESP, e[33:32]);
        chk("rdata", bus.S_AXI_RDATA, e[31:0]);
      end
      if (bus.S_AXI_ARVALID && bus.S_AXI_ARREADY) ar_p = 0;
      @(posedge clk);
      @(negedge clk);
    end
    bus.S_AXI_ARVALID = 0;
    bus.S_AXI_RREADY  = 0;
    chk("r_handshake", done, 1);
  endtask
  initial begin
    vec_t vt[16];
    int lat;
    int k;
    logic [3:0] an_exp[4];
    logic [6:0] ca_exp[4];
    vt[0]  = '{0, 5'h00, 32'h0, 4'h0, 2'b00, 32'h0000_00A5};
    vt[1]  = '{1, 5'h04, 32'h0000_1234, 4'hF, 2'b00, 32'h0};
    vt[2]  = '{0, 5'h04, 32'h0, 4'h0, 2'b00, 32'h0000_1234};
    vt[3]  = '{1, 5'h14, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0};
    vt[4]  = '{0, 5'h14, 32'h0, 4'h0, 2'b10, 32'h0};
    vt[5]  = '{0, 5'h00, 32'h0, 4'h0, 2'b00, 32'h0000_00A5};
    vt[6]  = '{0, 5'h04, 32'h0, 4'h0, 2'b00, 32'h0000_1234};
    vt[7]  = '{1, 5'h00, 32'h1234_5678, 4'h1, 2'b00, 32'h0};
    vt[8]  = '{0, 5'h00, 32'h0, 4'h0, 2'b00, 32'h0000_0078};
    vt[9]  = '{1, 5'h08, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0};
    vt[10] = '{0, 5'h08, 32'h0, 4'h0, 2'b00, 32'h0000_0001};
    vt[11] = '{1, 5'h08, 32'h0, 4'hF, 2'b00, 32'h0};
    vt[12] = '{0, 5'h0C, 32'h0, 4'h0, 2'b00, 32'h0};
    vt[13] = '{0, 5'h1C, 32'h0, 4'h0, 2'b10, 32'h0};
    vt[14] = '{1, 5'h04, 32'hFFFF_0000, 4'hC, 2'b00, 32'h0};
    vt[15] = '{0, 5'h04, 32'h0, 4'h0, 2'b00, 32'h0000_1234};
    an_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    ca_exp = '{7'h40, 7'h0E, 7'h40, 7'h00};
    rst = 1; ext = 0;
    bus.S_AXI_AWADDR = 0; bus.S_AXI_AWPROT = 0; bus.S_AXI_AWVALID = 0;
    bus.S_AXI_WDATA = 0; bus.S_AXI_WSTRB = 0; bus.S_AXI_WVALID = 0; bus.S_AXI_BREADY = 0;
    bus.S_AXI_ARADDR = 0; bus.S_AXI_ARPROT = 0; bus.S_AXI_ARVALID = 0; bus.S_AXI_RREADY = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b000);
    chk("rst_valid", {bus.S_AXI_BVALID, bus.S_AXI_RVALID, irq}, 3'b000);
    chk("rst_resp", {bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA}, 36'h0);
    chk("rst_led", led, 8'h00);
    chk("rst_seg", {anode, cath}, {4'b1111, 7'h7F});
    rst = 0;
    @(negedge clk);
    chk("rel_seg", {anode, cath}, {4'b1110, 7'h40});
    chk("rel_ready", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b111);
    axi_write(5'h00, 32'h0000_00A5, 4'hF, 0, 0, 2'b00, lat);
    chk("b_latency", lat, 2);
    chk("led_after_b", led, 8'hA5);
    for (int i = 0; i < 16; i++)
      if (vt[i].wr) axi_write(vt[i].addr, vt[i].data, vt[i].strb, 0, 0, vt[i].resp, lat);
      else axi_read(vt[i].addr, vt[i].resp, vt[i].rdata, i % 3);
    axi_write(5'h04, 32'h0000_3C00, 4'b0010, 3, 5, 2'b00, lat);
    chk("w_lead_latency", lat, 5);
    axi_read(5'h04, 2'b00, 32'h0000_3C34, 0);
    axi_write(5'h08, 32'h1, 4'h1, 0, 0, 2'b00, lat);
    ext = 1;
    for (k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 2) ext = 0;
      if (irq) break;
    end
    chk("irq_set", irq, 1);
    chk("irq_latency_le4", k <= 4, 1);
    ext = 0;
    repeat (4) @(negedge clk);
    axi_read(5'h0C, 2'b00, 32'h1, 0);
    axi_write(5'h0C, 32'h1, 4'h1, 0, 0, 2'b00, lat);
    @(negedge clk);
    chk("irq_clr", irq, 0);
    axi_read(5'h0C, 2'b00, 32'h0, 0);
    ext = 1;
    @(negedge clk);
    axi_write(5'h0C, 32'h1, 4'h1, 0, 0, 2'b00, lat);
    ext = 0;
    axi_read(5'h0C, 2'b00, 32'h1, 0);
    chk("irq_set_wins", irq, 1);
    axi_write(5'h04, 32'h0000_80F0, 4'hF, 0, 0, 2'b00, lat);
    for (k = 0; k < 20 && anode == 4'b1110; k++) @(negedge clk);
    for (k = 0; k < 20 && anode != 4'b1110; k++) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      chk("scan_anode", anode, an_exp[s]);
      chk("scan_cath", cath, ca_exp[s]);
      repeat (3) @(negedge clk);
      chk("scan_hold", anode, an_exp[s]);
      @(negedge clk);
    end
    bus.S_AXI_AWADDR = 0; bus.S_AXI_WDATA = 32'h55; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_ARADDR = 0;
    bus.S_AXI_AWVALID = 1; bus.S_AXI_WVALID = 1; bus.S_AXI_ARVALID = 1;
    @(negedge clk);
    bus.S_AXI_AWVALID = 0; bus.S_AXI_WVALID = 0; bus.S_AXI_ARVALID = 0;
    repeat (3) @(negedge clk);
    chk("pre_rst_valid", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 2'b11);
    rst = 1;
    #1;
    chk("async_rst_valid", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 2'b00);
    chk("async_rst_led", led, 8'h00);
    chk("async_rst_anode", anode, 4'b1111);
    @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    chk("post_rst_bvalid", bus.S_AXI_BVALID, 0);
    axi_read(5'h00, 2'b00, 32'h0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
